// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and lane helpers for the mem_arbiter front end
package mem_arbiter_pkg;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;
    localparam logic [3:0] WIDTH_BYTE = 4'd1;
    localparam logic [3:0] WIDTH_HALF = 4'd2;
    localparam logic [3:0] WIDTH_WORD = 4'd4;

    function automatic logic width_legal(input logic [3:0] w);
        return w == WIDTH_BYTE || w == WIDTH_HALF || w == WIDTH_WORD;
    endfunction

    // Any width other than byte/half decodes to a full word
    function automatic logic [3:0] width_mask(input logic [3:0] w);
        return w == WIDTH_BYTE ? 4'b0001 : w == WIDTH_HALF ? 4'b0011 : 4'b1111;
    endfunction

    function automatic logic [31:0] lane_expand(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// mem_rr_arbiter: round-robin grant over NUM_CH requests, owns last_gnt
// Ports: clk, rst (async active-low), req in, gnt one-hot out, gnt_idx out
module mem_rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int IW     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx
);
    logic [IW-1:0] r_last;
    logic          w_found;
    int            w_c;

    // Search starts one past the previous winner so every channel gets a turn
    always_comb begin
        w_found = FALSE;
        gnt_idx = '0;
        w_c     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_c = (int'(r_last) + i) % NUM_CH;
            if (!w_found && req[w_c]) begin
                w_found = TRUE;
                gnt_idx = w_c[IW-1:0];
            end
        end
        gnt = w_found ? NUM_CH'(1) << gnt_idx : '0;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_last <= IW'(NUM_CH - 1);
        else if (|req)
            r_last <= gnt_idx;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: NUM_CH requesters sharing one SRAM port with round-robin grant
// Ports: clk, rst (async active-low); per-channel ch_req_i/ch_we_i/ch_addr_i/
// ch_width_i/ch_data_i in, ch_gnt_o/ch_rvalid_o out, shared ch_rdata_o out;
// SRAM side sram_ce/sram_we/sram_addr_o/sram_sel_o/sram_data_o out, sram_data_i in.
// Macro MEM_ARB_ALIGN_CHK_EN adds ch_err_o and suppresses misaligned/illegal accesses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int ADDR_W = ADDR_BUS,
    parameter  int DATA_W = DATA_BUS,
    localparam int LANES  = DATA_W / 8,
    localparam int IW     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_we_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [NUM_CH*4-1:0]      ch_width_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
    output logic [NUM_CH-1:0]        ch_gnt_o,
    output logic [NUM_CH-1:0]        ch_rvalid_o,
    output logic [DATA_W-1:0]        ch_rdata_o,
`ifdef MEM_ARB_ALIGN_CHK_EN
    output logic [NUM_CH-1:0]        ch_err_o,
`endif
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_W-1:0]        sram_addr_o,
    output logic [LANES-1:0]         sram_sel_o,
    output logic [DATA_W-1:0]        sram_data_o,
    input  logic [DATA_W-1:0]        sram_data_i
);
    logic [NUM_CH-1:0] w_req;
    logic [IW-1:0]     w_idx;
    logic              w_any, w_we, w_bad;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_width, w_mask;
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_data;
    logic [7:0]        w_sel_full;
    logic              r_valid, r_bad;
    logic [IW-1:0]     r_ch;
    logic [1:0]        r_off;
    logic [3:0]        r_mask;

    // Requests are masked during reset so every output reads 0 while rst is low
    assign w_req = rst ? ch_req_i : '0;

    mem_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (w_req),
        .gnt     (ch_gnt_o),
        .gnt_idx (w_idx)
    );

    assign w_any      = |w_req;
    assign w_we       = ch_we_i[w_idx];
    assign w_addr     = ch_addr_i[w_idx*ADDR_W +: ADDR_W];
    assign w_width    = ch_width_i[w_idx*4 +: 4];
    assign w_data     = ch_data_i[w_idx*DATA_W +: DATA_W];
    assign w_off      = w_addr[1:0];
    assign w_mask     = width_mask(w_width);
    // Lanes shifted past the word boundary fall off when truncated to 4 bits
    assign w_sel_full = {4'b0000, w_mask} << w_off;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign w_bad = !width_legal(w_width) || ({2'b00, w_off} + w_width > 4'd4);
`else
    assign w_bad = FALSE;
`endif

    assign sram_ce     = w_any && !w_bad;
    assign sram_we     = sram_ce && w_we;
    assign sram_addr_o = sram_ce ? {2'b00, w_addr[ADDR_W-1:2]} : '0;
    assign sram_sel_o  = sram_ce ? w_sel_full[LANES-1:0] : '0;
    assign sram_data_o = sram_ce ? w_data << {w_off, 3'b000} : '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_valid <= FALSE;
            r_bad   <= FALSE;
            r_ch    <= '0;
            r_off   <= '0;
            r_mask  <= '0;
        end else begin
            r_valid <= w_any && !w_we;
            r_bad   <= w_any && w_bad;
            r_ch    <= w_idx;
            r_off   <= w_off;
            r_mask  <= w_mask;
        end

    assign ch_rvalid_o = r_valid ? NUM_CH'(1) << r_ch : '0;
    // A rejected read still returns, but with zero data
    assign ch_rdata_o  = (r_valid && !r_bad) ?
                         (sram_data_i >> {r_off, 3'b000}) & DATA_W'(lane_expand(r_mask)) : '0;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign ch_err_o = r_bad ? NUM_CH'(1) << r_ch : '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a byte-level reference model checked every cycle
module tb_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  ch_req_i = '0, ch_we_i = '0;
    logic [N*AW-1:0] ch_addr_i = '0;
    logic [N*4-1:0]  ch_width_i = '0;
    logic [N*DW-1:0] ch_data_i = '0;
    logic [N-1:0]  ch_gnt_o, ch_rvalid_o, ch_err_o;
    logic [DW-1:0] ch_rdata_o;
    logic          sram_ce, sram_we;
    logic [AW-1:0] sram_addr_o;
    logic [3:0]    sram_sel_o;
    logic [DW-1:0] sram_data_o;
    logic [DW-1:0] sram_rd = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req_i    (ch_req_i),
        .ch_we_i     (ch_we_i),
        .ch_addr_i   (ch_addr_i),
        .ch_width_i  (ch_width_i),
        .ch_data_i   (ch_data_i),
        .ch_gnt_o    (ch_gnt_o),
        .ch_rvalid_o (ch_rvalid_o),
        .ch_rdata_o  (ch_rdata_o),
`ifdef MEM_ARB_ALIGN_CHK_EN
        .ch_err_o    (ch_err_o),
`endif
        .sram_ce     (sram_ce),
        .sram_we     (sram_we),
        .sram_addr_o (sram_addr_o),
        .sram_sel_o  (sram_sel_o),
        .sram_data_o (sram_data_o),
        .sram_data_i (sram_rd)
    );
`ifndef MEM_ARB_ALIGN_CHK_EN
    assign ch_err_o = '0;
`endif

    // Word-organised SRAM seen by the DUT
    logic [31:0] mem [64];
    always @(posedge clk)
        if (sram_ce) begin
            if (sram_we) begin
                for (int l = 0; l < 4; l++)
                    if (sram_sel_o[l]) mem[sram_addr_o[5:0]][8*l +: 8] <= sram_data_o[8*l +: 8];
            end else
                sram_rd <= mem[sram_addr_o[5:0]];
        end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Byte-addressed reference memory plus expected next-cycle returns
    logic [7:0]  bm [256];
    int          m_last = N - 1;
    logic [N-1:0] exp_rv = '0, exp_err = '0, n_rv, n_err;
    logic [31:0] exp_rd = '0, n_rd, m_a, m_d, m_sel, m_dat;
    int          m_win, m_c, m_off, m_w, m_n, m_base;
    bit          m_we, m_legal, m_bad;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_gnt", ch_gnt_o, 0);
            chk("rst_rvalid", ch_rvalid_o, 0);
            chk("rst_rdata", ch_rdata_o, 0);
            chk("rst_err", ch_err_o, 0);
            chk("rst_ce", {sram_ce, sram_we}, 0);
            chk("rst_addr", sram_addr_o, 0);
            chk("rst_sel", sram_sel_o, 0);
            chk("rst_wdata", sram_data_o, 0);
            m_last = N - 1;
            exp_rv = '0;
            exp_rd = '0;
            exp_err = '0;
        end else begin
            chk("rvalid", ch_rvalid_o, exp_rv);
            chk("rdata", ch_rdata_o, exp_rd);
            chk("err", ch_err_o, exp_err);
            n_rv = '0;
            n_rd = '0;
            n_err = '0;
            m_win = -1;
            for (int k = 1; k <= N; k++) begin
                m_c = (m_last + k) % N;
                if (m_win < 0 && ch_req_i[m_c]) m_win = m_c;
            end
            if (m_win < 0) begin
                chk("idle_gnt", ch_gnt_o, 0);
                chk("idle_ce", {sram_ce, sram_we}, 0);
                chk("idle_addr", sram_addr_o, 0);
                chk("idle_sel", sram_sel_o, 0);
                chk("idle_wdata", sram_data_o, 0);
            end else begin
                m_a = ch_addr_i[m_win*AW +: AW];
                m_w = int'(ch_width_i[m_win*4 +: 4]);
                m_we = ch_we_i[m_win];
                m_d = ch_data_i[m_win*DW +: DW];
                m_off = int'(m_a[1:0]);
                m_base = int'(m_a[7:0]) - m_off;
                m_legal = m_w == 1 || m_w == 2 || m_w == 4;
                m_n = m_legal ? m_w : 4;
`ifdef MEM_ARB_ALIGN_CHK_EN
                m_bad = !m_legal || m_off + m_w > 4;
`else
                m_bad = 0;
`endif
                chk("gnt", ch_gnt_o, 1 << m_win);
                chk("ce", sram_ce, !m_bad);
                if (!m_bad) begin
                    m_sel = 0;
                    m_dat = 0;
                    for (int i = 0; i < m_n; i++)
                        if (m_off + i < 4) begin
                            m_sel[m_off+i] = 1'b1;
                            m_dat[8*(m_off+i) +: 8] = m_d[8*i +: 8];
                            if (m_we) bm[m_base+m_off+i] = m_d[8*i +: 8];
                            else n_rd[8*i +: 8] = bm[m_base+m_off+i];
                        end
                    chk("we", sram_we, m_we);
                    chk("addr", sram_addr_o, m_a >> 2);
                    chk("sel", sram_sel_o, m_sel);
                    chk("wdata", sram_data_o, m_dat);
                end
                if (!m_we) n_rv = N'(1) << m_win;
                if (m_bad) n_err = N'(1) << m_win;
                m_last = m_win;
            end
            exp_rv = n_rv;
            exp_rd = n_rd;
            exp_err = n_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rq(input int c, input bit we, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        ch_req_i[c] = 1'b1;
        ch_we_i[c] = we;
        ch_addr_i[c*AW +: AW] = a;
        ch_width_i[c*4 +: 4] = w;
        ch_data_i[c*DW +: DW] = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bm[i] = 8'(i * 7 + 3);
        {bm[67], bm[66], bm[65], bm[64]} = 32'hDEADBEEF;
        for (int w = 0; w < 64; w++) mem[w] = {bm[4*w+3], bm[4*w+2], bm[4*w+1], bm[4*w]};
        tick();
        tick();
        rst = 1'b1;
        // Word read at 0x40
        rq(0, 0, 32'h40, 4, 0);
        @(negedge clk);
        chk("A_gnt", ch_gnt_o, 1);
        chk("A_addr", sram_addr_o, 32'h10);
        chk("A_sel", sram_sel_o, 4'hF);
        tick();
        ch_req_i = '0;
        @(negedge clk);
        chk("A_rvalid", ch_rvalid_o, 1);
        chk("A_rdata", ch_rdata_o, 32'hDEADBEEF);
        tick();
        // Byte write then byte read at 0x43
        rq(1, 1, 32'h43, 1, 32'hA5);
        @(negedge clk);
        chk("B_gnt", ch_gnt_o, 2);
        chk("B_sel", sram_sel_o, 4'b1000);
        chk("B_wdata", sram_data_o, 32'hA500_0000);
        chk("B_addr", sram_addr_o, 32'h10);
        chk("B_we", sram_we, 1);
        tick();
        rq(1, 0, 32'h43, 1, 0);
        tick();
        ch_req_i = '0;
        @(negedge clk);
        chk("B_rvalid", ch_rvalid_o, 2);
        chk("B_rdata", ch_rdata_o, 32'h0000_00A5);
        tick();
        // Both channels contend; ch1 won last, so ch0 leads
        rq(0, 0, 32'h48, 4, 0);
        rq(1, 0, 32'h4C, 2, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("C_gnt", ch_gnt_o, (i % 2 == 0) ? 1 : 2);
            tick();
        end
        ch_req_i = '0;
        @(negedge clk);
        chk("C_rvalid", ch_rvalid_o, 2);
        tick();
        // Misaligned half-word read at 0x03
        rq(0, 0, 32'h03, 2, 0);
        @(negedge clk);
`ifdef MEM_ARB_ALIGN_CHK_EN
        chk("D_ce", sram_ce, 0);
`else
        chk("D_sel", sram_sel_o, 4'b1000);
`endif
        tick();
        ch_req_i = '0;
        @(negedge clk);
        chk("D_rvalid", ch_rvalid_o, 1);
`ifdef MEM_ARB_ALIGN_CHK_EN
        chk("D_err", ch_err_o, 1);
        chk("D_rdata", ch_rdata_o, 0);
`else
        chk("D_rdata", ch_rdata_o, 32'h18);
`endif
        tick();
        // Illegal width 3
        rq(1, 0, 32'h48, 3, 0);
        @(negedge clk);
`ifdef MEM_ARB_ALIGN_CHK_EN
        chk("E_ce", sram_ce, 0);
`else
        chk("E_sel", sram_sel_o, 4'hF);
`endif
        tick();
        ch_req_i = '0;
        tick();
        // Reset right after a read grant
        rq(0, 0, 32'h44, 4, 0);
        @(negedge clk);
        chk("F_gnt", ch_gnt_o, 1);
        tick();
        rst = 1'b0;
        rq(1, 0, 32'h4C, 4, 0);
        #1;
        chk("F_rst_gnt", ch_gnt_o, 0);
        chk("F_rst_rvalid", ch_rvalid_o, 0);
        chk("F_rst_rdata", ch_rdata_o, 0);
        chk("F_rst_ce", sram_ce, 0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("F_rel_gnt", ch_gnt_o, 1);
        chk("F_rel_rvalid", ch_rvalid_o, 0);
        tick();
        ch_req_i = '0;
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised shared-memory front end that lets `NUM_CH` requesters (executor instances, packet loaders) share one synchronous SRAM port. It replaces the single-channel `mem` width adapter and adds round-robin arbitration, a registered read-return stage and per-channel read-valid signalling. It sits between the executors and `sram` in the switch datapath.

## Interface
- `NUM_CH`, 2: number of requester channels, 1..8
- `ADDR_W`, 32: byte-address width per channel
- `DATA_W`, 32: data width; byte lanes `LANES = DATA_W/8`, must be 4 in this generation
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `ch_req_i` in NUM_CH: per-channel request, held until granted
- `ch_we_i` in NUM_CH: 1 = write, 0 = read
- `ch_addr_i` in NUM_CH*ADDR_W: byte addresses, channel k at `[k*ADDR_W +: ADDR_W]`
- `ch_width_i` in NUM_CH*4: access bytes, legal values 1, 2, 4
- `ch_data_i` in NUM_CH*DATA_W: write data, right-aligned
- `ch_gnt_o` out NUM_CH: one-hot grant, same cycle as the accepted request
- `ch_rvalid_o` out NUM_CH: one-hot read-return pulse
- `ch_rdata_o` out DATA_W: shared read data, valid when any `ch_rvalid_o` is high
- `ch_err_o` out NUM_CH: misalignment error pulse, present only with `MEM_ARB_ALIGN_CHK_EN`
- `sram_ce`, `sram_we` out 1: SRAM chip enable and write enable, active-high
- `sram_addr_o` out ADDR_W: word address, `addr >> 2`
- `sram_sel_o` out LANES: byte-lane enables
- `sram_data_o` out DATA_W: lane-shifted write data
- `sram_data_i` in DATA_W: SRAM read data, one cycle after the `sram_ce` read

## Operation
- Arbitration:
  - Combinational over `ch_req_i`, starting at `last_gnt+1` mod NUM_CH.
  - The winner gets `ch_gnt_o` and drives the SRAM port in the same cycle.
  - `last_gnt` updates on each grant.
- Byte select: `sram_sel_o = ((1<<width)-1) << addr[1:0]`, truncated to LANES bits.
- Write data: `ch_data << 8*addr[1:0]`.
- Read pipeline register captures `{valid, ch_id, offset, width}` at grant.
- At T+1:
  - `ch_rdata_o = (sram_data_i >> 8*offset)`, masked to `width` bytes and zero-extended.
  - `ch_rvalid_o[ch_id]` = 1.
- Writes produce no `rvalid`.
- No grant: `sram_ce` = 0 and the other SRAM outputs are 0.
- Back-to-back grants every cycle are legal. A read return at T+1 coexists with a new grant at T+1.
- A channel may re-request the cycle after its grant. It is re-granted only if no other channel requests.

## Timing
- Reset values:
  - All outputs 0.
  - `last_gnt` = NUM_CH-1, so channel 0 wins first.
  - Pipeline valid = 0.
- Latency: grant = 0 cycles after request (combinational); read data = 1 cycle after grant.
- Reset asserted mid-operation: the pending read is discarded, and no `rvalid` appears after reset release.
- Single requesting channel: granted every cycle it requests, regardless of `last_gnt`.
- NUM_CH = 1: arbiter degenerates to pass-through grant. `last_gnt` is constant 0.

## Configuration
- `MEM_ARB_ALIGN_CHK_EN` defined:
  - An access with `addr[1:0]+width > 4`, or an illegal width, is still granted.
  - `sram_ce` stays 0 for that access.
  - `ch_err_o[k]` pulses at T+1 for both reads and writes.
  - For reads, `ch_rvalid_o[k]` also pulses with `ch_rdata_o` = 0.
- Undefined:
  - The `ch_err_o` port is absent.
  - Misaligned accesses are issued with `sram_sel_o` truncated to the word, so upper bytes are dropped.
  - An illegal width is treated as 4.

## Structure
- Shared constants in `def.vh`: `TRUE`, `FALSE`, `ADDR_BUS`, `DATA_BUS`, plus new `WIDTH_BYTE`=1, `WIDTH_HALF`=2, `WIDTH_WORD`=4.
- Sub-module `mem_rr_arbiter` (parameter NUM_CH):
  - `req` in, one-hot `gnt` out, `gnt_idx` out.
  - Owns the `last_gnt` register.
- `mem_arbiter` contains the lane shifting, sel generation, read pipeline register and alignment check.

## Test plan
- Reset, then ch0 read width 4 at addr 0x40 with SRAM word 0xDEADBEEF -> `gnt[0]` same cycle; at T+1 `rvalid[0]` = 1 and `rdata` = 0xDEADBEEF.
- ch1 write width 1 at addr 0x43, data 0xA5 -> `sram_sel_o` = 4'b1000, `sram_data_o` = 0xA5000000, `sram_addr_o` = 0x10; the following read of 0x43 width 1 returns 0x000000A5.
- ch0 and ch1 both requesting continuously for 4 cycles -> grants 0,1,0,1; each read `rvalid` lands on the correct channel one cycle later.
- Width 2 read at addr 0x03:
  - With macro: no `sram_ce`, `err[k]` and `rvalid[k]` at T+1, `rdata` = 0.
  - Without macro: `sram_sel_o` = 4'b1000.
- Assert `rst` low the cycle after a read grant -> all outputs 0 immediately; after release no `rvalid`, and the next grant goes to ch0.
